ctrl_pipe_bp: RTL and testbench
===============================

// Module: ctrl_pipe_bp
// PURPOSE
//  Parametrised control-path pipeline for the 5-stage ARM core: carries decoded control D->E->M->W,
//  evaluates all 16 condition codes in E against a stored NZCV register, and predicts branches
//  with a 2^IDX_W-entry table of 2-bit saturating counters. Per-stage stall/flush from hazard unit.
//  Sits between the decoder and datapath; replaces the fixed 2-bit-ALU, flush-E-only controller.
// PARAMETERS
//  ACW       2      ALUControl width (2 = ADD/SUB/AND/ORR; 3+ for extended ALU ops)
//  IDX_W     4      BHT index width; table depth = 2**IDX_W; index = PCD[IDX_W+1:2]
//  CTR_INIT  2'b01  counter reset value (weakly not-taken)
// PORTS
//  clk           in   1      core clock, all state on rising edge
//  reset         in   1      asynchronous, active-low; clears all state
//  CondD         in   4      Instr[31:28] of D-stage instruction
//  PCSrcD        in   1      decoder: writes PC (Rd==15)
//  RegWriteD     in   1      decoder register write
//  MemtoRegD     in   1      decoder load select
//  MemWriteD     in   1      decoder store
//  BranchD       in   1      decoder B instruction
//  ALUSrcD       in   1      decoder immediate select
//  ALUControlD   in   ACW    decoder ALU op
//  FlagWriteD    in   2      [1]=update NZ, [0]=update CV
//  PCD           in   32     PC of D-stage instruction
//  ALUFlags      in   4      {N,Z,C,V} from E-stage ALU, combinational
//  StallE        in   1      hold D->E register and suppress E-side state updates
//  FlushE        in   1      clear D->E register (bubble)
//  FlushM        in   1      clear E->M register
//  PredTakenD    out  1      BranchD & counter[idx][1]
//  ALUSrcE       out  1      registered
//  ALUControlE   out  ACW    registered
//  MemtoRegE     out  1      registered
//  BranchTakenE  out  1      BranchE & CondExE
//  MispredictE   out  1      BranchE & (CondExE != PredTakenE)
//  FlagsE        out  4      current NZCV register
//  RegWriteM     out  1      CondEx-gated, registered
//  MemWriteM     out  1      CondEx-gated, registered
//  PCSrcW,RegWriteW,MemtoRegW  out  1 each  registered from M
// BEHAVIOUR
//  - Reset: every pipeline register, FlagsE = 0; all counters = CTR_INIT; all outputs 0.
//  - Latency: D->E, E->M, M->W one cycle each. M->W never stalls/flushes.
//  - D->E reg: FlushE -> all-zero (incl. BranchE, PredTakenE); else StallE -> hold; else load.
//    FlushE beats StallE when both asserted.
//  - CondExE from stored FlagsE (not ALUFlags): EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V;
//    VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 4'b1111 -> 0.
//  - Flags update at edge when CondExE & !StallE: FlagWriteE[1] -> N,Z from ALUFlags;
//    FlagWriteE[0] -> C,V from ALUFlags. Both bits independent.
//  - E->M reg loads {PCSrcE&CondExE, RegWriteE&CondExE, MemtoRegE, MemWriteE&CondExE};
//    FlushM -> zero. StallE -> E->M receives zeros (bubble into M).
//  - BHT read: combinational at IDX=PCD[IDX_W+1:2]; idx and PredTakenD piped with D->E reg.
//  - BHT update: when BranchE & !StallE: taken -> ctr+1 sat at 3; not taken -> ctr-1 sat at 0.
//    One update per branch instruction.
//  - Same-index read and write in one cycle: read returns pre-update value (no bypass).
//  - Non-branch in D: PredTakenD=0 regardless of counter.
//  - Reset mid-operation: immediate async clear; bubbles until new instructions enter D.
// STRUCTURE
//  - ctrl_pkg: localparams for the 16 condition codes, NZCV bit indices (N=3,Z=2,C=1,V=0),
//    counter constants (SNT=0,WNT=1,WT=2,ST=3).
//  - Sub-module branch_hist_table (params IDX_W, CTR_INIT): rd_idx, rd_ctr, wr_en, wr_idx,
//    taken; holds counter array + saturating update. Condition eval stays inline (function).
// TESTING
//  1 Reset low mid-stream with RegWriteD=1 -> all outputs 0 same cycle; counters read 01.
//  2 SUBS (FlagWriteD=11) ALUFlags=0100, then CondD=EQ RegWriteD=1 -> RegWriteM=1; CondD=NE -> 0.
//  3 Branch at PCD=0x40 taken 3 times -> PredTakenD 0,0,1,1 (ctr 01->10->11->11); MispredictE 1,1,0,0.
//  4 StallE=1 for 2 cycles on branch in E -> counter increments once; FlagsE unchanged during stall.
//  5 FlushE=1 & StallE=1 together -> ALUControlE=0, BranchTakenE=0 next cycle.
//  6 FlagWriteD=10 with ALUFlags=1111 from flags 0000 -> FlagsE=1100 (C,V kept); CondD=4'hF -> no writes.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants for the control-path pipeline and branch predictor
package ctrl_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;

endpackage

// File: rtl/branch_hist_table.sv
// branch_hist_table: array of 2-bit saturating counters with combinational read
module branch_hist_table
    import ctrl_pkg::*;
#(
    parameter int         IDX_W    = 4,
    parameter logic [1:0] CTR_INIT = CTR_WNT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             taken
);

    logic [1:0] ctr [2**IDX_W];
    logic [1:0] cur;
    logic [1:0] nxt;

    // read sees the stored value only, so a same-cycle update is not bypassed
    assign rd_ctr = ctr[rd_idx];
    assign cur    = ctr[wr_idx];

    // saturating step toward the resolved direction
    always_comb begin
        nxt = taken ? ((cur == CTR_ST) ? CTR_ST : cur + 2'd1)
                    : ((cur == CTR_SNT) ? CTR_SNT : cur - 2'd1);
    end

    // counter storage, cleared to the weakly-not-taken start value on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2**IDX_W; i++) ctr[i] <= CTR_INIT;
        end else if (wr_en) begin
            ctr[wr_idx] <= nxt;
        end
    end

endmodule

// File: rtl/ctrl_pipe_bp.sv
// ctrl_pipe_bp: D->E->M->W control pipeline with condition evaluation and branch prediction
module ctrl_pipe_bp
    import ctrl_pkg::*;
#(
    parameter int         ACW      = 2,
    parameter int         IDX_W    = 4,
    parameter logic [1:0] CTR_INIT = CTR_WNT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [3:0]     CondD,
    input  logic           PCSrcD,
    input  logic           RegWriteD,
    input  logic           MemtoRegD,
    input  logic           MemWriteD,
    input  logic           BranchD,
    input  logic           ALUSrcD,
    input  logic [ACW-1:0] ALUControlD,
    input  logic [1:0]     FlagWriteD,
    input  logic [31:0]    PCD,
    input  logic [3:0]     ALUFlags,
    input  logic           StallE,
    input  logic           FlushE,
    input  logic           FlushM,
    output logic           PredTakenD,
    output logic           ALUSrcE,
    output logic [ACW-1:0] ALUControlE,
    output logic           MemtoRegE,
    output logic           BranchTakenE,
    output logic           MispredictE,
    output logic [3:0]     FlagsE,
    output logic           RegWriteM,
    output logic           MemWriteM,
    output logic           PCSrcW,
    output logic           RegWriteW,
    output logic           MemtoRegW
);

    logic [IDX_W-1:0] idx_d;
    logic [IDX_W-1:0] idx_e;
    logic [1:0]       rd_ctr;
    logic [3:0]       cond_e;
    logic [1:0]       flagwrite_e;
    logic             pcsrc_e;
    logic             regwrite_e;
    logic             memwrite_e;
    logic             branch_e;
    logic             pred_e;
    logic             cond_ex_e;
    logic             pcsrc_m;
    logic             memtoreg_m;
    logic             unused_bits;

    function automatic logic cond_ex(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n  = f[FLAG_N];
        z  = f[FLAG_Z];
        cf = f[FLAG_C];
        v  = f[FLAG_V];
        case (c)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = !z;
            COND_CS: cond_ex = cf;
            COND_CC: cond_ex = !cf;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = !n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = !v;
            COND_HI: cond_ex = cf && !z;
            COND_LS: cond_ex = !cf || z;
            COND_GE: cond_ex = n == v;
            COND_LT: cond_ex = n != v;
            COND_GT: cond_ex = !z && (n == v);
            COND_LE: cond_ex = z || (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    endfunction

    assign idx_d        = PCD[IDX_W+1:2];
    assign unused_bits  = ^{PCD[31:IDX_W+2], PCD[1:0], rd_ctr[0]};
    assign PredTakenD   = BranchD & rd_ctr[1];
    assign cond_ex_e    = cond_ex(cond_e, FlagsE);
    assign BranchTakenE = branch_e & cond_ex_e;
    assign MispredictE  = branch_e & (cond_ex_e != pred_e);

    branch_hist_table #(.IDX_W(IDX_W), .CTR_INIT(CTR_INIT)) u_bht (
        .clk   (clk),
        .reset (reset),
        .rd_idx(idx_d),
        .rd_ctr(rd_ctr),
        .wr_en (branch_e & ~StallE),
        .wr_idx(idx_e),
        .taken (cond_ex_e)
    );

    // D->E register: flush wins over stall, stall holds the instruction in E
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {cond_e, pcsrc_e, regwrite_e, MemtoRegE, memwrite_e, branch_e, ALUSrcE} <= '0;
            {ALUControlE, flagwrite_e, idx_e, pred_e} <= '0;
        end else if (FlushE) begin
            {cond_e, pcsrc_e, regwrite_e, MemtoRegE, memwrite_e, branch_e, ALUSrcE} <= '0;
            {ALUControlE, flagwrite_e, idx_e, pred_e} <= '0;
        end else if (!StallE) begin
            {cond_e, pcsrc_e, regwrite_e, MemtoRegE, memwrite_e, branch_e, ALUSrcE} <=
                {CondD, PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD};
            {ALUControlE, flagwrite_e, idx_e, pred_e} <= {ALUControlD, FlagWriteD, idx_d, PredTakenD};
        end
    end

    // NZ and CV halves update independently, only for an executing, non-stalled instruction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            FlagsE <= '0;
        end else if (cond_ex_e && !StallE) begin
            if (flagwrite_e[1]) FlagsE[3:2] <= ALUFlags[3:2];
            if (flagwrite_e[0]) FlagsE[1:0] <= ALUFlags[1:0];
        end
    end

    // E->M register: side effects gated by the condition; a stalled E sends a bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {pcsrc_m, RegWriteM, memtoreg_m, MemWriteM} <= '0;
        end else if (FlushM || StallE) begin
            {pcsrc_m, RegWriteM, memtoreg_m, MemWriteM} <= '0;
        end else begin
            {pcsrc_m, RegWriteM, memtoreg_m, MemWriteM} <=
                {pcsrc_e & cond_ex_e, regwrite_e & cond_ex_e, MemtoRegE, memwrite_e & cond_ex_e};
        end
    end

    // M->W register: free-running
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {PCSrcW, RegWriteW, MemtoRegW} <= '0;
        end else begin
            {PCSrcW, RegWriteW, MemtoRegW} <= {pcsrc_m, RegWriteM, memtoreg_m};
        end
    end

endmodule

// File: tb/tb_ctrl_pipe_bp.sv
// tb_ctrl_pipe_bp: directed vector table, reset sequence and randomized model check
module tb_ctrl_pipe_bp;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  CondD = 4'hE;
    logic        PCSrcD = 0, RegWriteD = 0, MemtoRegD = 0, MemWriteD = 0, BranchD = 0, ALUSrcD = 0;
    logic [1:0]  ALUControlD = 0, FlagWriteD = 0;
    logic [31:0] PCD = 0;
    logic [3:0]  ALUFlags = 0;
    logic        StallE = 0, FlushE = 0, FlushM = 0;
    logic        PredTakenD, ALUSrcE, MemtoRegE, BranchTakenE, MispredictE;
    logic [1:0]  ALUControlE;
    logic [3:0]  FlagsE;
    logic        RegWriteM, MemWriteM, PCSrcW, RegWriteW, MemtoRegW;
    logic [15:0] dut_vec;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    ctrl_pipe_bp dut (
        .clk(clk), .reset(reset), .CondD(CondD), .PCSrcD(PCSrcD), .RegWriteD(RegWriteD),
        .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
        .ALUControlD(ALUControlD), .FlagWriteD(FlagWriteD), .PCD(PCD), .ALUFlags(ALUFlags),
        .StallE(StallE), .FlushE(FlushE), .FlushM(FlushM), .PredTakenD(PredTakenD),
        .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .MemtoRegE(MemtoRegE),
        .BranchTakenE(BranchTakenE), .MispredictE(MispredictE), .FlagsE(FlagsE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .PCSrcW(PCSrcW),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW)
    );

    assign dut_vec = {PredTakenD, ALUSrcE, ALUControlE, MemtoRegE, BranchTakenE, MispredictE,
                      FlagsE, RegWriteM, MemWriteM, PCSrcW, RegWriteW, MemtoRegW};

    // reference model: one record per occupied stage, counters as plain integers
    typedef struct packed {
        logic [3:0] cond;
        logic       pcsrc, regw, mtr, memw, br, alusrc;
        logic [1:0] aluc, fw;
        logic [3:0] idx;
        logic       pred;
    } de_t;

    de_t        me;
    logic [3:0] mflags;
    logic [3:0] mm;
    logic [2:0] mw;
    int         ctr [16];

    // ARM rule: pairs share a base test, odd code inverts it, 111x is always/never
    function automatic bit cond_ok(logic [3:0] c, logic [3:0] f);
        bit n, z, cf, v, b;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cf;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cf && !z;
            3'd5: b = n == v;
            3'd6: b = !z && (n == v);
            default: return c == 4'hE;
        endcase
        return c[0] ? !b : b;
    endfunction

    task automatic model_reset();
        me = '0;
        mflags = '0;
        mm = '0;
        mw = '0;
        for (int i = 0; i < 16; i++) ctr[i] = 1;
    endtask

    function automatic logic [15:0] exp_vec();
        bit cx;
        cx = cond_ok(me.cond, mflags);
        return {BranchD && ctr[PCD[5:2]] >= 2, me.alusrc, me.aluc, me.mtr, me.br && cx,
                me.br && (cx != me.pred), mflags, mm[2], mm[0], mw};
    endfunction

    task automatic model_edge();
        bit  cx;
        de_t nd;
        cx = cond_ok(me.cond, mflags);
        nd = '{CondD, PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD,
               ALUControlD, FlagWriteD, PCD[5:2], BranchD && ctr[PCD[5:2]] >= 2};
        if (me.br && !StallE) ctr[me.idx] = cx ? (ctr[me.idx] < 3 ? ctr[me.idx] + 1 : 3)
                                               : (ctr[me.idx] > 0 ? ctr[me.idx] - 1 : 0);
        if (cx && !StallE) begin
            if (me.fw[1]) mflags[3:2] = ALUFlags[3:2];
            if (me.fw[0]) mflags[1:0] = ALUFlags[1:0];
        end
        mw = mm[3:1];
        mm = (FlushM || StallE) ? 4'b0 : {me.pcsrc && cx, me.regw && cx, me.mtr, me.memw && cx};
        me = FlushE ? '0 : (StallE ? me : nd);
    endtask

    task automatic chk(string nm, logic [15:0] got, logic [15:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
        end
    endtask

    // directed vectors: inputs for one cycle plus the outputs expected during that cycle
    typedef struct {
        logic [3:0]  cond;
        logic        regw, memw, br;
        logic [1:0]  aluc, fw;
        logic [31:0] pc;
        logic [3:0]  af;
        logic        st, fe;
        logic [5:0]  msk;
        logic        p, mi, bt, rw;
        logic [3:0]  fl;
        logic [1:0]  ac;
    } row_t;

    function automatic row_t r(logic [3:0] cond, logic regw, logic memw, logic br, logic [1:0] aluc,
                               logic [1:0] fw, logic [31:0] pc, logic [3:0] af, logic st, logic fe,
                               logic [5:0] msk, logic p, logic mi, logic bt, logic rw,
                               logic [3:0] fl, logic [1:0] ac);
        return '{cond, regw, memw, br, aluc, fw, pc, af, st, fe, msk, p, mi, bt, rw, fl, ac};
    endfunction

    function automatic row_t idle(logic st, logic fe, logic [5:0] msk, logic mi, logic bt,
                                  logic rw, logic [3:0] fl, logic [1:0] ac);
        return r(4'hE, 0, 0, 0, 2'd0, 2'd0, 32'h0, 4'h0, st, fe, msk, 0, mi, bt, rw, fl, ac);
    endfunction

    task automatic set_row(row_t x);
        {CondD, RegWriteD, MemWriteD, BranchD, ALUControlD, FlagWriteD} =
            {x.cond, x.regw, x.memw, x.br, x.aluc, x.fw};
        {PCD, ALUFlags, StallE, FlushE} = {x.pc, x.af, x.st, x.fe};
        {PCSrcD, MemtoRegD, ALUSrcD, FlushM} = 4'b0;
    endtask

    task automatic cyc();
        @(negedge clk);
        chk("model", dut_vec, exp_vec());
        @(posedge clk);
        model_edge();
        #1;
    endtask

    row_t rows [26];

    initial begin
        rows[0]  = r(4'hE, 0, 0, 0, 2'd1, 2'd3, 32'h0, 4'h0, 0, 0, 6'b000000, 0, 0, 0, 0, 4'h0, 2'd0);
        rows[1]  = r(4'h0, 1, 0, 0, 2'd0, 2'd0, 32'h0, 4'h4, 0, 0, 6'b000001, 0, 0, 0, 0, 4'h0, 2'd1);
        rows[2]  = r(4'h1, 1, 0, 0, 2'd0, 2'd0, 32'h0, 4'h0, 0, 0, 6'b000010, 0, 0, 0, 0, 4'h4, 2'd0);
        rows[3]  = idle(0, 0, 6'b000100, 0, 0, 1, 4'h0, 2'd0);
        rows[4]  = idle(0, 0, 6'b000100, 0, 0, 0, 4'h0, 2'd0);
        rows[5]  = r(4'hE, 0, 0, 0, 2'd0, 2'd3, 32'h0, 4'h0, 0, 0, 6'b000000, 0, 0, 0, 0, 4'h0, 2'd0);
        rows[6]  = r(4'hE, 0, 0, 0, 2'd0, 2'd2, 32'h0, 4'h0, 0, 0, 6'b000000, 0, 0, 0, 0, 4'h0, 2'd0);
        rows[7]  = r(4'hF, 1, 1, 0, 2'd0, 2'd0, 32'h0, 4'hF, 0, 0, 6'b000010, 0, 0, 0, 0, 4'h0, 2'd0);
        rows[8]  = idle(0, 0, 6'b000010, 0, 0, 0, 4'hC, 2'd0);
        rows[9]  = idle(0, 0, 6'b000100, 0, 0, 0, 4'h0, 2'd0);
        rows[10] = r(4'hE, 0, 0, 1, 2'd0, 2'd0, 32'h40, 4'h0, 0, 0, 6'b100000, 0, 0, 0, 0, 4'h0, 2'd0);
        rows[11] = r(4'hE, 0, 0, 1, 2'd0, 2'd0, 32'h40, 4'h0, 0, 0, 6'b110000, 0, 1, 0, 0, 4'h0, 2'd0);
        rows[12] = r(4'hE, 0, 0, 1, 2'd0, 2'd0, 32'h40, 4'h0, 0, 0, 6'b110000, 1, 1, 0, 0, 4'h0, 2'd0);
        rows[13] = r(4'hE, 0, 0, 1, 2'd0, 2'd0, 32'h40, 4'h0, 0, 0, 6'b110000, 1, 0, 0, 0, 4'h0, 2'd0);
        rows[14] = idle(0, 0, 6'b010000, 0, 0, 0, 4'h0, 2'd0);
        rows[15] = r(4'hE, 0, 0, 1, 2'd0, 2'd0, 32'h44, 4'h0, 0, 0, 6'b100000, 0, 0, 0, 0, 4'h0, 2'd0);
        rows[16] = idle(1, 0, 6'b001010, 0, 1, 0, 4'hC, 2'd0);
        rows[17] = idle(1, 0, 6'b001010, 0, 1, 0, 4'hC, 2'd0);
        rows[18] = idle(0, 0, 6'b001000, 0, 1, 0, 4'h0, 2'd0);
        rows[19] = r(4'hF, 0, 0, 1, 2'd0, 2'd0, 32'h44, 4'h0, 0, 0, 6'b100000, 1, 0, 0, 0, 4'h0, 2'd0);
        rows[20] = idle(0, 0, 6'b001000, 0, 0, 0, 4'h0, 2'd0);
        rows[21] = r(4'hE, 0, 0, 1, 2'd0, 2'd0, 32'h44, 4'h0, 0, 0, 6'b100000, 0, 0, 0, 0, 4'h0, 2'd0);
        rows[22] = idle(0, 0, 6'b000000, 0, 0, 0, 4'h0, 2'd0);
        rows[23] = r(4'hE, 1, 0, 1, 2'd3, 2'd0, 32'h48, 4'h0, 0, 0, 6'b100000, 0, 0, 0, 0, 4'h0, 2'd0);
        rows[24] = idle(1, 1, 6'b001001, 0, 1, 0, 4'h0, 2'd3);
        rows[25] = idle(0, 0, 6'b001001, 0, 0, 0, 4'h0, 2'd0);

        model_reset();
        #1 reset = 1'b0;
        #2 chk("reset_state", dut_vec, 16'h0);
        @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < 26; i++) begin
            set_row(rows[i]);
            @(negedge clk);
            chk($sformatf("model_row%0d", i), dut_vec, exp_vec());
            if (rows[i].msk[5]) chk($sformatf("pred_row%0d", i), 16'(PredTakenD), 16'(rows[i].p));
            if (rows[i].msk[4]) chk($sformatf("misp_row%0d", i), 16'(MispredictE), 16'(rows[i].mi));
            if (rows[i].msk[3]) chk($sformatf("btaken_row%0d", i), 16'(BranchTakenE), 16'(rows[i].bt));
            if (rows[i].msk[2]) chk($sformatf("regwm_row%0d", i), 16'(RegWriteM), 16'(rows[i].rw));
            if (rows[i].msk[1]) chk($sformatf("flags_row%0d", i), 16'(FlagsE), 16'(rows[i].fl));
            if (rows[i].msk[0]) chk($sformatf("aluc_row%0d", i), 16'(ALUControlE), 16'(rows[i].ac));
            @(posedge clk);
            model_edge();
            #1;
        end

        // asynchronous reset in the middle of a stream of register writes
        set_row(idle(0, 0, 6'b0, 0, 0, 0, 4'h0, 2'd0));
        RegWriteD = 1'b1;
        repeat (3) cyc();
        #3 reset = 1'b0;
        #1 chk("async_reset_outputs", dut_vec, 16'h0);
        BranchD = 1'b1;
        PCD = 32'h40;
        #1 chk("async_reset_counter", 16'(PredTakenD), 16'h0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        RegWriteD = 1'b0;
        cyc();

        for (int i = 0; i < 500; i++) begin
            CondD       = 4'($urandom_range(0, 15));
            {PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD} = 6'($urandom);
            ALUControlD = 2'($urandom);
            FlagWriteD  = 2'($urandom);
            PCD         = ($urandom & 32'hFFFF_FFC0) | (32'($urandom_range(0, 5)) << 2) | 32'($urandom_range(0, 3));
            ALUFlags    = 4'($urandom);
            StallE      = ($urandom_range(0, 7) == 0);
            FlushE      = ($urandom_range(0, 9) == 0);
            FlushM      = ($urandom_range(0, 9) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
